// File: rtl/carry_select_pkg.sv
// Shared types for the carry-select subtract pipeline: default geometry and
// the stage-1 register layout.
package carry_select_pkg;

   localparam int WIDTH_DEFAULT = 16;
   localparam int SPLIT_DEFAULT = 8;
   localparam int HI_DEFAULT    = WIDTH_DEFAULT - SPLIT_DEFAULT;

   typedef struct packed {
      logic [SPLIT_DEFAULT-1:0] low;
      logic                     c_lo;
      logic [HI_DEFAULT-1:0]    hi0;
      logic                     co0;
      logic [HI_DEFAULT-1:0]    hi1;
      logic                     co1;
      logic                     a_msb;
      logic                     b_msb;
   } sub_s1_t;

endpackage

// File: rtl/cs_block_add.sv
// Combinational W-bit adder block with carry-in and carry-out; the building
// brick for the low half and both upper carry-select candidates.
module cs_block_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/carry_select_subtractor16_pipe.sv
// Two-stage carry-select subtractor: diff = a - b - bin with borrow, zero and
// signed-overflow flags, valid/ready flow control on both stages.
module carry_select_subtractor16_pipe
   import carry_select_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SPLIT = SPLIT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int HI = WIDTH - SPLIT;

   // The stage-1 register is laid out from the package geometry.
   if (WIDTH != WIDTH_DEFAULT || SPLIT != SPLIT_DEFAULT) begin : g_bad_cfg
      $error("carry_select_subtractor16_pipe: WIDTH/SPLIT must match carry_select_pkg defaults");
   end

   logic    s1_valid, s2_valid;
   logic    adv1, adv2;
   sub_s1_t s1, s1_next;

   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;

   // Subtraction as a + ~b + ~bin; the upper half is precomputed for both carries.
   cs_block_add #(.W(SPLIT)) u_lo (
      .x (a[SPLIT-1:0]),
      .y (~b[SPLIT-1:0]),
      .ci(~bin),
      .s (s1_next.low),
      .co(s1_next.c_lo)
   );

   cs_block_add #(.W(HI)) u_hi0 (
      .x (a[WIDTH-1:SPLIT]),
      .y (~b[WIDTH-1:SPLIT]),
      .ci(1'b0),
      .s (s1_next.hi0),
      .co(s1_next.co0)
   );

   cs_block_add #(.W(HI)) u_hi1 (
      .x (a[WIDTH-1:SPLIT]),
      .y (~b[WIDTH-1:SPLIT]),
      .ci(1'b1),
      .s (s1_next.hi1),
      .co(s1_next.co1)
   );

   assign s1_next.a_msb = a[WIDTH-1];
   assign s1_next.b_msb = b[WIDTH-1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) s1 <= s1_next;
      end
   end

   logic [HI-1:0]    hi_sel;
   logic             co_sel;
   logic [WIDTH-1:0] d_next;

   // A carry out of the low half means no borrow crossed SPLIT.
   assign hi_sel = s1.c_lo ? s1.hi1 : s1.hi0;
   assign co_sel = s1.c_lo ? s1.co1 : s1.co0;
   assign d_next = {hi_sel, s1.low};

   // NOTE: the datapath registers are reset too, so a freshly reset block
   // presents all-zero outputs rather than stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         zero     <= 1'b0;
         ovf      <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            diff <= d_next;
            bout <= ~co_sel;
            zero <= (d_next == '0);
            ovf  <= (s1.a_msb != s1.b_msb) && (d_next[WIDTH-1] != s1.a_msb);
         end
      end
   end

endmodule

// File: tb/tb_carry_select_subtractor16_pipe.sv
// Self-checking bench for carry_select_subtractor16_pipe: directed boundary
// vectors, stall/back-pressure, async reset and randomized traffic.
module tb_carry_select_subtractor16_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout, zero, ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        z;
      logic        ov;
   } exp_t;

   exp_t q[$];
   exp_t next_exp;

   carry_select_subtractor16_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .bout     (bout),
      .zero     (zero),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the unsigned and signed readings.
   function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb, input logic xbin);
      exp_t e;
      int   ur, sr, sa, sb;
      ur   = int'(xa) - int'(xb) - int'(xbin);
      sa   = int'($signed(xa));
      sb   = int'($signed(xb));
      sr   = sa - sb - int'(xbin);
      e.d  = ur[15:0];
      e.bo = (ur < 0);
      e.z  = (ur[15:0] == 16'h0000);
      e.ov = (sr > 32767) || (sr < -32768);
      return e;
   endfunction

   function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic z, input logic ov);
      exp_t e;
      e.d = d; e.bo = bo; e.z = z; e.ov = ov;
      return e;
   endfunction

   // One clock: check any delivery at negedge, log any accept, then move to posedge+1.
   task automatic tick(output bit acc);
      exp_t e;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got diff=%h with nothing outstanding", diff);
         end else begin
            e = q.pop_front();
            if ({diff, bout, zero, ovf} !== {e.d, e.bo, e.z, e.ov}) begin
               errors++;
               $display("FAIL result: got diff=%h bout=%b zero=%b ovf=%b, want diff=%h bout=%b zero=%b ovf=%b",
                        diff, bout, zero, ovf, e.d, e.bo, e.z, e.ov);
            end
         end
      end
      if (acc) q.push_back(next_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xbin, input exp_t ex);
      bit acc;
      int n;
      a = xa; b = xb; bin = xbin; next_exp = ex; in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         tick(acc);
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: operands a=%h b=%h not accepted within 50 cycles", xa, xb);
      end
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      while (q.size() != 0 && n < 50) begin
         tick(acc);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results still outstanding, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, diff, bout, zero, ovf} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want all 0",
                  out_valid, diff, bout, zero, ovf);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   // Accept in cycle 0, out_valid must appear in cycle 2 and not before.
   task automatic test_latency(input logic [15:0] xa, input logic [15:0] xb, input logic xbin, input exp_t ex);
      bit acc;
      out_ready = 1'b1;
      a = xa; b = xb; bin = xbin; next_exp = ex; in_valid = 1'b1;
      tick(acc);
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL latency_accept: got accepted=%b, want 1", acc);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got out_valid=%b in cycle 1, want 0", out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== ex.d) begin
         errors++;
         $display("FAIL latency_cycle2: got out_valid=%b diff=%h, want 1 %h", out_valid, diff, ex.d);
      end
      drain();
   endtask

   task automatic test_boundaries();
      out_ready = 1'b1;
      send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
      send(16'h0100, 16'h0000, 1'b1, mk(16'h00FF, 1'b0, 1'b0, 1'b0));
      send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b0, 1'b1));
      send(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b0, 1'b1));
      send(16'h00FF, 16'h00FF, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0));
      send(16'h0000, 16'h0000, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
      send(16'hFFFF, 16'h0000, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
      drain();
   endtask

   task automatic test_stall();
      bit acc;
      logic [15:0] va[3] = '{16'h5555, 16'h0300, 16'hA000};
      logic [15:0] vb[3] = '{16'h1111, 16'h0001, 16'h2000};
      int k = 0;
      out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         a = va[k]; b = vb[k]; bin = 1'b0; next_exp = model(va[k], vb[k], 1'b0); in_valid = 1'b1;
         tick(acc);
         if (acc) k++;
      end
      checks++;
      if (k != 2) begin
         errors++;
         $display("FAIL stall_accepts: got %0d accepted of 3 offered, want 2", k);
      end
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || q.size() == 0 || diff !== q[0].d) begin
            errors++;
            $display("FAIL stall_hold: got in_ready=%b out_valid=%b diff=%h, want 0 1 %h",
                     in_ready, out_valid, diff, (q.size() != 0) ? q[0].d : 16'h0);
         end
         tick(acc);
      end
      out_ready = 1'b1;
      tick(acc);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL stall_release_accept: got third input accepted=%b, want 1", acc);
      end
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_random();
      bit acc;
      int sent = 0;
      int guard = 0;
      logic [15:0] ra, rb;
      logic rbin;
      in_valid = 1'b0;
      while (sent < 300 && guard < 5000) begin
         out_ready = ($urandom_range(3) != 0);
         if (!in_valid && $urandom_range(4) != 0) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            if ($urandom_range(7) == 0) rb = ra;
            a = ra; b = rb; bin = rbin; next_exp = model(ra, rb, rbin);
            in_valid = 1'b1;
         end
         tick(acc);
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
         guard++;
      end
      checks++;
      if (sent != 300) begin
         errors++;
         $display("FAIL random_progress: got %0d sent, want 300", sent);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(16'h4321, 16'h1234, 1'b0, model(16'h4321, 16'h1234, 1'b0));
      send(16'h0F0F, 16'h00F0, 1'b1, model(16'h0F0F, 16'h00F0, 1'b1));
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_full: got out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, diff, bout, zero, ovf} !== 20'h0) begin
         errors++;
         $display("FAIL reset_mid_async: got valid=%b diff=%h bout=%b zero=%b ovf=%b, want all 0",
                  out_valid, diff, bout, zero, ovf);
      end
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      test_latency(16'h0000, 16'h0000, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
   endtask

   initial begin
      test_reset();
      test_latency(16'h1234, 16'h0234, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0));
      test_boundaries();
      test_stall();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
